// File: rtl/vtree_refill_arbiter_pkg.sv
// Shared types and constants for the vtree leaf refill arbiter.
package vtree_refill_arbiter_pkg;

    localparam int unsigned DATW_DEF = 64;
    localparam int unsigned KEYW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    // Sentinel records are all ones so their key orders after every real key.
    localparam logic SENTINEL_FILL = 1'b1;

endpackage

// File: rtl/vtree_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, searching upward modulo N.
module vtree_rr_pick #(
    parameter int unsigned W_LOG = 5
) (
    input  logic [(1<<W_LOG)-1:0] req,
    input  logic [W_LOG-1:0]      ptr,
    output logic [(1<<W_LOG)-1:0] gnt_c,
    output logic [W_LOG-1:0]      idx_c,
    output logic                  vld_c
);
    localparam int unsigned N = 1 << W_LOG;

    always_comb begin
        logic [W_LOG-1:0] cand;
        gnt_c = '0;
        idx_c = '0;
        vld_c = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ptr + W_LOG'(k);
            if (!vld_c && req[cand]) begin
                vld_c = 1'b1;
                idx_c = cand;
            end
        end
        gnt_c[idx_c] = vld_c;
    end

endmodule

// File: rtl/vtree_refill_arbiter.sv
// Demand-driven leaf refill scheduler for the virtual merge-sorter tree.
// Build macro VTREE_SENTINEL_EN appends an all-ones sentinel batch after each way's last batch.
module vtree_refill_arbiter
    import vtree_refill_arbiter_pkg::*;
#(
    parameter int unsigned W_LOG    = 5,
    parameter int unsigned P_LOG    = 3,
    parameter int unsigned DATW     = DATW_DEF,
    parameter int unsigned KEYW     = KEYW_DEF,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  start,
    input  logic [(1<<W_LOG)*(DATW<<P_LOG)-1:0]   src_data,
    input  logic [(1<<W_LOG)-1:0]                 src_valid,
    input  logic [(1<<W_LOG)-1:0]                 src_last,
    output logic [(1<<W_LOG)-1:0]                 src_ready,
    input  logic [(1<<W_LOG)-1:0]                 tree_emp,
    output logic [(DATW<<P_LOG)-1:0]              dot,
    output logic                                  doten,
    output logic [W_LOG-1:0]                      dot_idx,
    output logic                                  busy,
    output logic                                  done
);
    localparam int unsigned N    = 1 << W_LOG;
    localparam int unsigned BATW = DATW << P_LOG;
    localparam int unsigned RECS = 1 << P_LOG;
    localparam int unsigned HW   = $clog2(HOLD_CYC + 1);
    // Key (low KEYW bits) and payload both saturated.
    localparam logic [DATW-1:0] SENT_REC   = {{(DATW-KEYW){SENTINEL_FILL}}, {KEYW{SENTINEL_FILL}}};
    localparam logic [BATW-1:0] SENT_BATCH = {RECS{SENT_REC}};

    arb_state_t       state_q, state_d;
    logic [HW-1:0]    drain_q, drain_d;
    logic             done_d;
    logic             run_start;
    logic [W_LOG-1:0] ptr_q;
    logic [HW-1:0]    hold_q [N];
    logic [N-1:0]     finished_q, sent_due_q;
    logic [N-1:0]     pending, elig, gnt, fin_set, due_set;
    logic [W_LOG-1:0] gnt_idx;
    logic             gnt_vld, serve_sent;
    logic [BATW-1:0]  gnt_batch;

    assign run_start = (state_q == ST_IDLE) && start;
    assign gnt_batch = src_data[gnt_idx * BATW +: BATW];

    // Ways that may take a batch this cycle; nothing is consumed while in reset.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < N; i++) pending[i] = (hold_q[i] != '0);
        elig = '0;
        if (state_q == ST_RUN && !RST)
            elig = tree_emp & ~pending & ~finished_q & (src_valid | sent_due_q);
    end

    vtree_rr_pick #(.W_LOG(W_LOG)) u_pick (
        .req   (elig),
        .ptr   (ptr_q),
        .gnt_c (gnt),
        .idx_c (gnt_idx),
        .vld_c (gnt_vld)
    );

    // Pop and termination decode for the current grant.
    always_comb begin
        serve_sent = gnt_vld & sent_due_q[gnt_idx];
        src_ready  = serve_sent ? '0 : gnt;
`ifdef VTREE_SENTINEL_EN
        fin_set    = serve_sent ? gnt : '0;
        due_set    = serve_sent ? '0 : (gnt & src_last);
`else
        fin_set    = gnt & src_last;
        due_set    = '0;
`endif
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (&(finished_q | fin_set)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == HW'(HOLD_CYC - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + HW'(1);
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            busy    <= (state_d != ST_IDLE);
            done    <= done_d;
        end
    end

    // Batch output, pointer and per-way hold/termination tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q      <= '0;
            finished_q <= '0;
            sent_due_q <= '0;
            dot        <= '0;
            doten      <= 1'b0;
            dot_idx    <= '0;
            for (int unsigned i = 0; i < N; i++) hold_q[i] <= '0;
        end else begin
            doten <= gnt_vld;
            if (gnt_vld) begin
                dot     <= serve_sent ? SENT_BATCH : gnt_batch;
                dot_idx <= gnt_idx;
                ptr_q   <= gnt_idx + W_LOG'(1);
            end
            if (run_start) begin
                ptr_q      <= '0;
                finished_q <= '0;
                sent_due_q <= '0;
                for (int unsigned i = 0; i < N; i++) hold_q[i] <= '0;
            end else begin
                finished_q <= finished_q | fin_set;
                sent_due_q <= (sent_due_q | due_set) & ~fin_set;
                for (int unsigned i = 0; i < N; i++) begin
                    if (gnt[i])          hold_q[i] <= HW'(HOLD_CYC);
                    else if (pending[i]) hold_q[i] <= hold_q[i] - HW'(1);
                end
            end
        end
    end

endmodule
